// File: rtl/log_capture_ctrl.sv
// Capture sequencer for the TX PHY logging path: enables PRBS/SRRC, flushes the
// filter, arms the I/Q log RAMs and streams the captured words out over valid/ready.
module log_capture_ctrl #(
    parameter int NB_ADDR        = 10,
    parameter int NB_DATA        = 32,
    parameter int FLUSH_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RD_LATENCY     = 2,
    parameter int NB_CNT         = 16
) (
    input  logic               clock,
    input  logic               in_reset,
    input  logic               in_start,
    input  logic               in_abort,
    input  logic               in_ram_full,
    input  logic [NB_DATA-1:0] in_ram_data,
    input  logic               in_out_ready,
    output logic               out_prbs_enable,
    output logic               out_srrc_enable,
    output logic               out_ram_run,
    output logic [NB_ADDR-1:0] out_ram_addr,
    output logic [NB_DATA-1:0] out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic               out_busy,
    output logic               out_done,
    output logic               out_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FLUSH     = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_READ_ADDR = 3'd3;
    localparam logic [2:0] S_READ_WAIT = 3'd4;
    localparam logic [2:0] S_READ_HOLD = 3'd5;

    localparam logic [NB_CNT-1:0] FLUSH_LAST   = NB_CNT'(FLUSH_CYCLES - 1);
    localparam logic [NB_CNT-1:0] TIMEOUT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        LAT_LOAD     = 3'(RD_LATENCY - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [NB_CNT-1:0] cnt;
    logic [2:0]        lat_cnt;
    logic              abort_req;
    logic              xfer;

    assign abort_req = in_abort && (state != S_IDLE);
    // out_valid is always set while holding, so ready alone marks a transfer
    assign xfer      = (state == S_READ_HOLD) && in_out_ready;

    always_comb begin
        state_nxt = state;
        if (abort_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (in_start) state_nxt = S_FLUSH;
                S_FLUSH:     if (cnt == FLUSH_LAST) state_nxt = S_CAPTURE;
                S_CAPTURE: begin
                    if (in_ram_full)              state_nxt = S_READ_ADDR;
                    else if (cnt == TIMEOUT_LAST) state_nxt = S_IDLE;
                end
                S_READ_ADDR: state_nxt = S_READ_WAIT;
                S_READ_WAIT: if (lat_cnt == 3'd0) state_nxt = S_READ_HOLD;
                S_READ_HOLD: if (xfer) state_nxt = out_last ? S_IDLE : S_READ_ADDR;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            lat_cnt         <= '0;
            out_prbs_enable <= 1'b0;
            out_srrc_enable <= 1'b0;
            out_ram_run     <= 1'b0;
            out_ram_addr    <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_error       <= 1'b0;
        end else begin
            state           <= state_nxt;
            // enables are decoded from the next state so they line up with it
            out_prbs_enable <= (state_nxt == S_FLUSH) || (state_nxt == S_CAPTURE);
            out_srrc_enable <= (state_nxt == S_FLUSH) || (state_nxt == S_CAPTURE);
            out_ram_run     <= (state_nxt == S_CAPTURE);
            out_busy        <= (state_nxt != S_IDLE);
            out_done        <= 1'b0;
            if (abort_req) begin
                cnt          <= '0;
                out_valid    <= 1'b0;
                out_last     <= 1'b0;
                out_ram_addr <= '0;
                out_error    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_start) begin
                            out_error <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                    S_FLUSH: begin
                        if (cnt == FLUSH_LAST) cnt <= '0;
                        else                   cnt <= cnt + 1'b1;
                    end
                    S_CAPTURE: begin
                        if (in_ram_full) begin
                            cnt          <= '0;
                            out_ram_addr <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt       <= '0;
                            out_error <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_READ_ADDR: lat_cnt <= LAT_LOAD;
                    S_READ_WAIT: begin
                        if (lat_cnt == 3'd0) begin
                            out_data  <= in_ram_data;
                            out_valid <= 1'b1;
                            out_last  <= &out_ram_addr;
                        end else begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end
                    end
                    S_READ_HOLD: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_last) begin
                                out_done     <= 1'b1;
                                out_ram_addr <= '0;
                            end else begin
                                out_ram_addr <= out_ram_addr + 1'b1;
                            end
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Directed bench for log_capture_ctrl: nominal readout, backpressure, timeout,
// abort, async reset and start-while-busy, against an addr*3 RAM model.
module tb_log_capture_ctrl;

    localparam int NB_ADDR = 3;
    localparam int NB_DATA = 32;

    logic               clock = 1'b0;
    logic               in_reset = 1'b0;
    logic               in_start = 1'b0;
    logic               in_abort = 1'b0;
    logic               in_ram_full = 1'b0;
    logic [NB_DATA-1:0] in_ram_data;
    logic               in_out_ready = 1'b1;
    logic               out_prbs_enable, out_srrc_enable, out_ram_run;
    logic [NB_ADDR-1:0] out_ram_addr;
    logic [NB_DATA-1:0] out_data;
    logic               out_valid, out_last, out_busy, out_done, out_error;

    int checks = 0;
    int errors = 0;

    log_capture_ctrl #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .FLUSH_CYCLES(4),
        .TIMEOUT_CYCLES(20), .RD_LATENCY(2), .NB_CNT(16)
    ) dut (
        .clock(clock), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
        .in_ram_full(in_ram_full), .in_ram_data(in_ram_data), .in_out_ready(in_out_ready),
        .out_prbs_enable(out_prbs_enable), .out_srrc_enable(out_srrc_enable),
        .out_ram_run(out_ram_run), .out_ram_addr(out_ram_addr), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_busy(out_busy),
        .out_done(out_done), .out_error(out_error)
    );

    always #5 clock = ~clock;

    // two-cycle read pipeline returning addr*3
    logic [NB_DATA-1:0] ram_d1 = '0, ram_d2 = '0;
    always @(posedge clock) begin
        ram_d1 <= NB_DATA'(out_ram_addr) * 32'd3;
        ram_d2 <= ram_d1;
    end
    assign in_ram_data = ram_d2;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [NB_DATA-1:0] rec_data[$];
    logic               rec_last[$];
    int                 rec_cyc[$];
    int                 done_cnt = 0;
    always @(negedge clock) begin
        if (!in_reset) begin
            if (out_valid && in_out_ready && !in_abort) begin
                rec_data.push_back(out_data);
                rec_last.push_back(out_last);
                rec_cyc.push_back(cyc);
            end
            if (out_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic clear_rec();
        rec_data.delete(); rec_last.delete(); rec_cyc.delete();
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 in_start = 1'b1;
        @(posedge clock); #1 in_start = 1'b0;
    endtask

    // start, count enable-only cycles until ram_run, then raise full on CAPTURE cycle full_at
    task automatic start_and_fill(input int full_at, output int flush_len);
        flush_len = -1;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_ram_run) begin
                flush_len = (flush_len < 0) ? 0 : flush_len;
                break;
            end
            if (out_prbs_enable && out_srrc_enable) flush_len = (flush_len < 0) ? 1 : flush_len + 1;
        end
        if (full_at > 0) begin
            repeat (full_at - 1) @(posedge clock);
            #1 in_ram_full = 1'b1;
            @(posedge clock); #1 in_ram_full = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (out_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        #1;
        checks++;
        if ({out_prbs_enable, out_srrc_enable, out_ram_run, out_ram_addr, out_data, out_valid,
             out_last, out_busy, out_done, out_error} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, need all 0");
        end
        @(posedge clock); #1 in_reset = 1'b0;
        @(negedge clock);
        checks++;
        if (out_busy !== 1'b0 || out_prbs_enable !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b prbs=%b need 0 0", out_busy, out_prbs_enable);
        end
    endtask

    task automatic test_nominal();
        int fl; bit ok; int d0;
        clear_rec(); in_out_ready = 1'b1; d0 = done_cnt;
        start_and_fill(10, fl);
        checks++;
        if (fl != 4) begin errors++; $display("FAIL nom_flush_len: got %0d need 4", fl); end
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nom_done: no done pulse within bound"); end
        checks++;
        if (out_busy !== 1'b0 || out_error !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL nom_done_state: busy=%b err=%b valid=%b need 0 0 0", out_busy, out_error, out_valid);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL nom_done_count: got %0d need 1", done_cnt - d0); end
        checks++;
        if (rec_data.size() != 8) begin errors++; $display("FAIL nom_word_count: got %0d need 8", rec_data.size()); end
        for (int i = 0; i < rec_data.size(); i++) begin
            checks++;
            if (rec_data[i] !== 32'(i * 3) || rec_last[i] !== (i == 7)) begin
                errors++; $display("FAIL nom_word%0d: got %0d last=%b need %0d last=%b", i, rec_data[i], rec_last[i], i * 3, (i == 7));
            end
            if (i > 0) begin
                checks++;
                if (rec_cyc[i] - rec_cyc[i-1] != 4) begin
                    errors++; $display("FAIL nom_spacing%0d: got %0d need 4", i, rec_cyc[i] - rec_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int fl; bit ok; bit prev_hold; logic [NB_DATA-1:0] pd; logic pl; bit seen;
        clear_rec(); in_out_ready = 1'b1;
        start_and_fill(10, fl);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid && out_ram_addr == 3'd1;
        end
        @(posedge clock); #1 in_out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_word2_wait: word 2 never valid"); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd6 || out_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b data=%0d last=%b need 1 6 0", k, out_valid, out_data, out_last);
            end
            if (k < 4) @(negedge clock);
        end
        ok = 1'b0; prev_hold = 1'b0; pd = '0; pl = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1 in_out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    errors++; $display("FAIL bp_stable: valid=%b data=%0d last=%b need 1 %0d %b", out_valid, out_data, out_last, pd, pl);
                end
            end
            prev_hold = out_valid && !in_out_ready;
            pd = out_data; pl = out_last;
            if (out_done) begin ok = 1'b1; break; end
        end
        in_out_ready = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done: no done pulse within bound"); end
        checks++;
        if (rec_data.size() != 8) begin errors++; $display("FAIL bp_word_count: got %0d need 8", rec_data.size()); end
        for (int i = 0; i < rec_data.size(); i++) begin
            checks++;
            if (rec_data[i] !== 32'(i * 3) || rec_last[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_word%0d: got %0d last=%b need %0d last=%b", i, rec_data[i], rec_last[i], i * 3, (i == 7));
            end
        end
    endtask

    task automatic test_timeout();
        int fl; int n; bit ok;
        clear_rec(); in_out_ready = 1'b1;
        start_and_fill(0, fl);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!out_ram_run) break;
            n++;
        end
        checks++;
        if (n != 20) begin errors++; $display("FAIL to_capture_len: got %0d need 20", n); end
        checks++;
        if (out_error !== 1'b1 || out_busy !== 1'b0 || out_prbs_enable !== 1'b0 || out_srrc_enable !== 1'b0) begin
            errors++; $display("FAIL to_state: err=%b busy=%b prbs=%b srrc=%b need 1 0 0 0", out_error, out_busy, out_prbs_enable, out_srrc_enable);
        end
        // restart; full lands on the same cycle as the timeout
        start_and_fill(20, fl);
        checks++;
        if (out_error !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b need 0", out_error); end
        wait_done(200, ok);
        checks++;
        if (!ok || out_error !== 1'b0) begin errors++; $display("FAIL to_tie_full_wins: done=%b err=%b need 1 0", ok, out_error); end
        checks++;
        if (rec_data.size() != 8) begin errors++; $display("FAIL to_tie_words: got %0d need 8", rec_data.size()); end
    endtask

    task automatic test_abort();
        int fl; bit seen; int d0;
        start_and_fill(0, fl);
        repeat (3) @(posedge clock);
        #1 in_abort = 1'b1;
        @(posedge clock); #1 in_abort = 1'b0;
        @(negedge clock);
        checks++;
        if (out_busy !== 1'b0 || out_ram_run !== 1'b0 || out_prbs_enable !== 1'b0 || out_error !== 1'b1) begin
            errors++; $display("FAIL ab_capture: busy=%b run=%b prbs=%b err=%b need 0 0 0 1", out_busy, out_ram_run, out_prbs_enable, out_error);
        end
        // abort on the valid&ready cycle of word 5
        clear_rec(); in_out_ready = 1'b1; d0 = done_cnt;
        start_and_fill(10, fl);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid && out_ram_addr == 3'd4;
        end
        @(posedge clock); #1 in_out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        checks++;
        if (!seen || out_data !== 32'd15) begin errors++; $display("FAIL ab_word5_wait: seen=%b data=%0d need 1 15", seen, out_data); end
        @(posedge clock); #1 in_out_ready = 1'b1; in_abort = 1'b1;
        @(posedge clock); #1 in_abort = 1'b0;
        @(negedge clock);
        checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0 || out_error !== 1'b1 || out_ram_addr !== 3'd0) begin
            errors++; $display("FAIL ab_xfer: busy=%b valid=%b err=%b addr=%0d need 0 0 1 0", out_busy, out_valid, out_error, out_ram_addr);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (done_cnt != d0 || rec_data.size() != 5) begin
            errors++; $display("FAIL ab_no_done: done=%0d words=%0d need 0 5", done_cnt - d0, rec_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int fl; bit seen; bit ok;
        in_out_ready = 1'b1;
        start_and_fill(10, fl);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid && out_ram_addr == 3'd3;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_word3_wait: word 3 never valid"); end
        in_reset = 1'b1;
        #1;
        checks++;
        if ({out_prbs_enable, out_srrc_enable, out_ram_run, out_ram_addr, out_data, out_valid,
             out_last, out_busy, out_done, out_error} !== '0) begin
            errors++; $display("FAIL rst_async: valid=%b data=%0d busy=%b, need all 0", out_valid, out_data, out_busy);
        end
        @(posedge clock); #1 in_reset = 1'b0;
        clear_rec();
        start_and_fill(10, fl);
        wait_done(200, ok);
        checks++;
        if (!ok || fl != 4 || rec_data.size() != 8) begin
            errors++; $display("FAIL rst_clean_run: done=%b flush=%0d words=%0d need 1 4 8", ok, fl, rec_data.size());
        end
        for (int i = 0; i < rec_data.size(); i++) begin
            checks++;
            if (rec_data[i] !== 32'(i * 3)) begin errors++; $display("FAIL rst_word%0d: got %0d need %0d", i, rec_data[i], i * 3); end
        end
    endtask

    task automatic test_start_busy();
        int fl; bit seen; bit ok;
        clear_rec(); in_out_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clock);
                #1 in_start = 1'b1;
                @(posedge clock); #1 in_start = 1'b0;
            end
        join_none
        start_and_fill(10, fl);
        checks++;
        if (fl != 4) begin errors++; $display("FAIL sb_flush_len: got %0d need 4", fl); end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        @(posedge clock); #1 in_start = 1'b1;
        @(posedge clock); #1 in_start = 1'b0; in_out_ready = 1'b1;
        wait_done(200, ok);
        checks++;
        if (!ok || rec_data.size() != 8) begin errors++; $display("FAIL sb_readout: done=%b words=%0d need 1 8", ok, rec_data.size()); end
        repeat (6) @(negedge clock);
        checks++;
        if (out_busy !== 1'b0 || out_prbs_enable !== 1'b0) begin
            errors++; $display("FAIL sb_no_restart: busy=%b prbs=%b need 0 0", out_busy, out_prbs_enable);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_capture_ctrl.md
Name: log_capture_ctrl

Overview:
- Sequencer for the TX PHY logging path; replaces manual VIO/micro control of the PRBS/SRRC enables, log-RAM run and read address.
- On a start command it enables the PRBS and SRRC, waits for the filter pipeline to flush, and arms both I/Q log RAMs until they report full.
- It then streams every RAM word out over a valid/ready interface and reports done, or reports an error on timeout or abort.

Parameters:
- NB_ADDR, 10, log RAM address width; depth = 2**NB_ADDR.
- NB_DATA, 32, merged {Q,I} RAM word width.
- FLUSH_CYCLES, 64, clock cycles between enabling the datapath and arming the RAM (1..2**NB_CNT-1).
- TIMEOUT_CYCLES, 65535, maximum CAPTURE cycles before the error is raised (1..2**NB_CNT-1).
- RD_LATENCY, 2, cycles from address presentation to valid in_ram_data (1..7).
- NB_CNT, 16, width of the shared flush/timeout counter.

Ports:
- clock  in  1  system clock.
- in_reset  in  1  asynchronous, active-high reset.
- in_start  in  1  single-cycle start request; honoured only in IDLE.
- in_abort  in  1  abort request; honoured in any state except IDLE.
- in_ram_full  in  1  AND of the I and Q RAM full flags.
- in_ram_data  in  NB_DATA  merged RAM read data.
- in_out_ready  in  1  downstream ready for out_data.
- out_prbs_enable  out  1  PRBS enable.
- out_srrc_enable  out  1  SRRC enable.
- out_ram_run  out  1  RAM load/run enable.
- out_ram_addr  out  NB_ADDR  RAM read address.
- out_data  out  NB_DATA  captured RAM word.
- out_valid  out  1  out_data valid.
- out_last  out  1  qualifies the final word (address 2**NB_ADDR-1).
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse when readout completes.
- out_error  out  1  sticky timeout/abort flag; cleared by the next accepted in_start.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, including out_data, out_ram_addr and out_error. Counters go to 0. Reset is async-asserted; release is clocked.
- All outputs are registered; state decode drives the enables.
- IDLE:
  - All enables are 0.
  - in_start=1 clears out_error and the counter, then moves to FLUSH.
- FLUSH:
  - prbs_enable=1 and srrc_enable=1.
  - Counter increments each cycle; when counter==FLUSH_CYCLES-1, clear counter and move to CAPTURE.
- CAPTURE:
  - prbs, srrc and ram_run are all 1.
  - in_ram_full=1 moves to READ_ADDR with out_ram_addr=0; the enables drop the next cycle.
  - Otherwise, when counter==TIMEOUT_CYCLES-1, set out_error and go to IDLE.
  - If full and timeout occur in the same cycle, full wins.
- READ_ADDR:
  - Presents out_ram_addr and loads the latency counter with RD_LATENCY-1, then moves to READ_WAIT.
  - ram_run stays 0.
- READ_WAIT:
  - Latency counter decrements each cycle; at 0, register in_ram_data into out_data.
  - Set out_valid=1, and set out_last=1 if out_ram_addr is all ones; move to READ_HOLD.
- READ_HOLD:
  - out_valid, out_data and out_last stay stable until in_out_ready=1.
  - A transfer occurs on the cycle valid&ready; the next cycle out_valid=0.
  - If last: pulse out_done and go to IDLE, with out_ram_addr returned to 0.
  - Otherwise: out_ram_addr+1, then READ_ADDR.
  - in_out_ready while out_valid=0 is ignored.
- Throughput: one word per RD_LATENCY+2 cycles, minimum.
- Address wrap: never wraps during a readout; the last address terminates the sequence.
- Abort:
  - in_abort in FLUSH/CAPTURE/READ_*: next cycle go to IDLE, drop all enables and out_valid, set out_error, reset out_ram_addr to 0.
  - Abort has priority over full, timeout and a valid&ready transfer in the same cycle; that transfer is not counted and out_done is not pulsed.
- in_start outside IDLE is ignored. Start and abort together in IDLE: start wins (abort is meaningless in IDLE).
- in_ram_full is ignored outside CAPTURE.
- Reset mid-operation: immediate return to the reset values, including mid-handshake (out_valid drops asynchronously).

Test Plan:
- Nominal (NB_ADDR=3, FLUSH_CYCLES=4, RD_LATENCY=2): pulse start; raise full 10 cycles into CAPTURE; ready tied 1; RAM model returns addr*3.
  - prbs/srrc high 4 cycles before ram_run.
  - Exactly 8 words 0,3,…,21, each 4 cycles apart; out_last on word 21.
  - out_done pulses once; out_busy falls the same cycle; out_error=0.
- Backpressure: ready low for 5 cycles on word 2 and toggled randomly afterwards → out_data/out_last stay stable while valid&!ready; no word is lost or duplicated; the 8-word sequence is intact.
- Timeout (TIMEOUT_CYCLES=20): full never asserted → after 20 CAPTURE cycles out_error=1, all enables 0, IDLE.
  - A second start clears out_error.
  - Full and timeout in the same cycle → readout proceeds with no error.
- Abort: in_abort during CAPTURE, and separately on a valid&ready cycle of word 5 → next cycle IDLE, out_valid=0, out_error=1, no out_done, addr=0.
- Reset mid-readout at word 3 → all outputs 0 immediately (async); a subsequent start performs a full clean sequence.
- Start ignored when busy: in_start pulsed during FLUSH and READ_HOLD → no restart, flush count unaffected.
